mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single byte-serial memory controller between instruction fetch (IF) and the load/store buffer (LSB).
- Latches one requester's transaction and holds the controller's inputs stable until the controller reports ready.
- Returns the result and a one-cycle done pulse to the winning requester.
- Fixed priority to LSB with an anti-starvation counter for IF; aborts on RoB_clear.

Parameters:
STARVE_LIMIT, 4, consecutive LSB grants while IF waits before IF is forced to win.
CNT_W, 3, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset; asynchronous, active-high
rdy_in  input  1  global stall when low
RoB_clear  input  1  pipeline flush
if_valid  input  1  IF request; held until if_done
if_addr  input  32  IF word address
if_done  output  1  IF transaction complete (one-cycle pulse)
if_data  output  32  fetched word; valid while if_done=1
ls_valid  input  1  LSB request; held until ls_done
ls_wr  input  1  1=store, 0=load
ls_len  input  3  [1:0] 0/1/2 = 1/2/4 bytes; [2] = signed load
ls_addr  input  32  LSB byte address
ls_value  input  32  store data
ls_done  output  1  LSB transaction complete (one-cycle pulse)
ls_data  output  32  load result; valid while ls_done=1
mc_waiting  output  1  request to memory controller
mc_wr  output  1  to controller
mc_len  output  3  to controller
mc_addr  output  32  to controller
mc_value  output  32  to controller
mc_ready  input  1  controller finished current request
mc_result  input  32  controller read result; valid with mc_ready

Behaviour:
- Reset (async, rst_in=1): state=IDLE; all outputs 0; latched request=0; streak=0.
- rdy_in=0: all registers hold, including pulses; outputs keep their values.
- States: IDLE, BUSY_IF, BUSY_LS.
- mc_waiting=1 only in BUSY_*. mc_* are driven from the latched request registers only, never directly from requester inputs.
- IDLE arbitration:
  - A requester whose done output is currently 1 is ineligible this cycle; it has not yet dropped valid.
  - Only LSB eligible: grant LSB.
  - Only IF eligible: grant IF.
  - Both eligible: grant IF if streak==STARVE_LIMIT, else grant LSB.
- Grant: latch the request and enter BUSY_x on the same edge.
  - IF grant latches wr=0, len=3'b010, addr=if_addr, value=0.
  - LSB grant latches ls_wr/ls_len/ls_addr/ls_value.
- Streak counter:
  - LSB granted while if_valid=1: streak+1, saturating at STARVE_LIMIT.
  - IF granted, or IF not requesting at a grant: streak=0.
- BUSY_x: when mc_ready=1, capture mc_result into x_data, set x_done=1 for exactly one active cycle, go to IDLE.
  - Minimum latency, grant edge to done: 1 cycle plus controller latency.
  - mc_ready=1 on the first BUSY cycle is legal and completes immediately.
- x_done clears on the next active edge. x_data holds until the next completion for that requester.
- Store completion: ls_done pulses; ls_data = mc_result (don't-care).
- Requester drops valid mid-transaction: the transaction still completes and done still pulses. Inputs changing while BUSY are ignored.
- RoB_clear=1 (sync, priority over everything except reset): state=IDLE, both done=0, mc_waiting=0 on the next edge, streak=0, no capture even if mc_ready=1 that cycle. Requesters re-issue after the flush.
- Only one requester may be in flight. No done pulse is ever generated for a non-granted requester.

Test Plan:
- Reset: rst_in pulsed asynchronously mid-BUSY_LS -> all outputs 0 immediately, state IDLE; no ls_done after release.
- IF only: if_addr=0x0000_1000; controller returns 0xDEADBEEF after 4 cycles -> mc_len=3'b010 and mc_addr=0x1000 held stable; if_done one cycle; if_data=0xDEADBEEF.
- Contention: if_valid and ls_valid both held, LSB load len=3'b100 addr=0x20, each transaction 2 cycles -> LSB wins 4 times, then IF is granted; streak returns to 0.
- Done-cycle masking: LSB keeps ls_valid=1 during the ls_done cycle -> no regrant in that cycle; regrant only if valid is still high the cycle after.
- RoB_clear arriving the same cycle as mc_ready in BUSY_IF -> no if_done; mc_waiting=0 next cycle; pending ls_valid granted the cycle after.
- Stall: rdy_in=0 for 3 cycles during an ls_done pulse -> ls_done stays 1 throughout and clears one active cycle after rdy_in returns.

Source files
------------

// File: rtl/mem_arbiter_if.sv
`default_nettype none
//============================================================================
// Module      : mem_arbiter_if
// Description : Request/response bundle between the instruction-fetch
//               unit, the load/store buffer, the memory arbiter and the
//               byte-serial memory controller.
//               'master' is the arbiter's view: it answers both requesters
//               and is the bus master towards the memory controller.
//               'slave' is the view of the surrounding requesters and
//               controller.
// Revision    : 1.0 - initial release
//============================================================================
interface mem_arbiter_if;

    // Instruction fetch side
    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;

    // Load/store buffer side
    logic        ls_valid;
    logic        ls_wr;
    logic [2:0]  ls_len;
    logic [31:0] ls_addr;
    logic [31:0] ls_value;
    logic        ls_done;
    logic [31:0] ls_data;

    // Memory controller side
    logic        mc_waiting;
    logic        mc_wr;
    logic [2:0]  mc_len;
    logic [31:0] mc_addr;
    logic [31:0] mc_value;
    logic        mc_ready;
    logic [31:0] mc_result;

    modport master (
        input  if_valid, if_addr,
        output if_done, if_data,
        input  ls_valid, ls_wr, ls_len, ls_addr, ls_value,
        output ls_done, ls_data,
        output mc_waiting, mc_wr, mc_len, mc_addr, mc_value,
        input  mc_ready, mc_result
    );

    modport slave (
        output if_valid, if_addr,
        input  if_done, if_data,
        output ls_valid, ls_wr, ls_len, ls_addr, ls_value,
        input  ls_done, ls_data,
        input  mc_waiting, mc_wr, mc_len, mc_addr, mc_value,
        output mc_ready, mc_result
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
//============================================================================
// Module      : mem_arbiter
// Description : Shares one byte-serial memory controller between
//               instruction fetch (IF) and the load/store buffer (LSB).
//               One transaction is latched at a time and presented to the
//               controller until it reports ready; the result and a
//               one-cycle done pulse go back to the winner. LSB has fixed
//               priority, but after STARVE_LIMIT consecutive LSB grants
//               with IF waiting, IF is forced through. RoB_clear aborts.
// Revision    : 1.0 - initial release
//============================================================================
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,   // LSB grants in a row before IF wins
    parameter int CNT_W        = 3    // streak counter width, must hold STARVE_LIMIT
) (
    input  logic          clk_in,
    input  logic          rst_in,     // asynchronous, active-high
    input  logic          rdy_in,     // global stall when low
    input  logic          RoB_clear,  // pipeline flush
    mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_LS = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_streak_max = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] c_streak_one = CNT_W'(1);
    localparam logic [2:0]       c_if_len     = 3'b010;   // whole word

    state_t            r_state;
    state_t            w_state_nxt;

    // Latched transaction presented to the controller
    logic              r_wr;
    logic              w_wr_nxt;
    logic [2:0]        r_len;
    logic [2:0]        w_len_nxt;
    logic [31:0]       r_addr;
    logic [31:0]       w_addr_nxt;
    logic [31:0]       r_value;
    logic [31:0]       w_value_nxt;

    // Per-requester response registers
    logic              r_if_done;
    logic              w_if_done_nxt;
    logic [31:0]       r_if_data;
    logic [31:0]       w_if_data_nxt;
    logic              r_ls_done;
    logic              w_ls_done_nxt;
    logic [31:0]       r_ls_data;
    logic [31:0]       w_ls_data_nxt;

    // Consecutive LSB grants taken while IF was requesting
    logic [CNT_W-1:0]  r_streak;
    logic [CNT_W-1:0]  w_streak_nxt;

    logic              w_if_elig;
    logic              w_ls_elig;
    logic              w_grant_if;
    logic              w_grant_ls;

    // Eligibility and arbitration. A requester showing done this cycle has
    // not yet seen its pulse, so its still-high valid must not regrant.
    always_comb begin
        w_if_elig  = bus.if_valid && !r_if_done;
        w_ls_elig  = bus.ls_valid && !r_ls_done;
        w_grant_if = w_if_elig && (!w_ls_elig || (r_streak == c_streak_max));
        w_grant_ls = w_ls_elig && !w_grant_if;
    end

    // Next-state and next-register values for an active (rdy_in=1) cycle
    always_comb begin
        w_state_nxt   = r_state;
        w_wr_nxt      = r_wr;
        w_len_nxt     = r_len;
        w_addr_nxt    = r_addr;
        w_value_nxt   = r_value;
        w_if_done_nxt = 1'b0;          // done is a single active-cycle pulse
        w_ls_done_nxt = 1'b0;
        w_if_data_nxt = r_if_data;
        w_ls_data_nxt = r_ls_data;
        w_streak_nxt  = r_streak;

        case (r_state)
            ST_IDLE: begin
                if (w_grant_ls) begin
                    w_state_nxt = ST_BUSY_LS;
                    w_wr_nxt    = bus.ls_wr;
                    w_len_nxt   = bus.ls_len;
                    w_addr_nxt  = bus.ls_addr;
                    w_value_nxt = bus.ls_value;
                    // Only grants taken over a requesting IF count as starvation
                    if (!bus.if_valid) begin
                        w_streak_nxt = '0;
                    end else if (r_streak != c_streak_max) begin
                        w_streak_nxt = r_streak + c_streak_one;
                    end
                end else if (w_grant_if) begin
                    w_state_nxt  = ST_BUSY_IF;
                    w_wr_nxt     = 1'b0;
                    w_len_nxt    = c_if_len;
                    w_addr_nxt   = bus.if_addr;
                    w_value_nxt  = 32'd0;
                    w_streak_nxt = '0;
                end
            end

            ST_BUSY_IF: begin
                if (bus.mc_ready) begin
                    w_if_data_nxt = bus.mc_result;
                    w_if_done_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end

            ST_BUSY_LS: begin
                // Stores also capture mc_result; the LSB ignores ls_data then
                if (bus.mc_ready) begin
                    w_ls_data_nxt = bus.mc_result;
                    w_ls_done_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register: flush beats stall, stall freezes everything
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else if (RoB_clear) begin
            r_state <= ST_IDLE;
        end else if (rdy_in) begin
            r_state <= w_state_nxt;
        end
    end

    // Transaction, response and streak registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr      <= 1'b0;
            r_len     <= 3'd0;
            r_addr    <= 32'd0;
            r_value   <= 32'd0;
            r_if_done <= 1'b0;
            r_if_data <= 32'd0;
            r_ls_done <= 1'b0;
            r_ls_data <= 32'd0;
            r_streak  <= '0;
        end else if (RoB_clear) begin
            // Abort: no capture even if the controller answers this cycle.
            // The latched request is left as is; mc_waiting drops with state.
            r_if_done <= 1'b0;
            r_ls_done <= 1'b0;
            r_streak  <= '0;
        end else if (rdy_in) begin
            r_wr      <= w_wr_nxt;
            r_len     <= w_len_nxt;
            r_addr    <= w_addr_nxt;
            r_value   <= w_value_nxt;
            r_if_done <= w_if_done_nxt;
            r_if_data <= w_if_data_nxt;
            r_ls_done <= w_ls_done_nxt;
            r_ls_data <= w_ls_data_nxt;
            r_streak  <= w_streak_nxt;
        end
    end

    // Controller inputs come only from the latched request
    assign bus.mc_waiting = (r_state != ST_IDLE);
    assign bus.mc_wr      = r_wr;
    assign bus.mc_len     = r_len;
    assign bus.mc_addr    = r_addr;
    assign bus.mc_value   = r_value;

    assign bus.if_done    = r_if_done;
    assign bus.if_data    = r_if_data;
    assign bus.ls_done    = r_ls_done;
    assign bus.ls_data    = r_ls_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
//============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A transaction-level
//               model (who owns the controller, pending done pulses,
//               starvation count) predicts every output each cycle;
//               directed scenarios are followed by random traffic.
// Revision    : 1.0 - initial release
//============================================================================
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic RoB_clear;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .CNT_W        (3)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .RoB_clear (RoB_clear),
        .bus       (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: owner 0 = nobody, 1 = IF, 2 = LSB
    int          m_owner;
    bit          m_if_done;
    bit          m_ls_done;
    logic [31:0] m_if_data;
    logic [31:0] m_ls_data;
    int          m_streak;
    logic        m_wr;
    logic [2:0]  m_len;
    logic [31:0] m_addr;
    logic [31:0] m_value;
    int          m_age;
    int          m_lat;

    // Controller behaviour knobs
    int          lat_cfg;      // <0 : random latency per transaction
    bit          use_fix;
    logic [31:0] res_fix;

    bit          if_after;
    bit          ls_after;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = 0;
        m_if_done = 1'b0;
        m_ls_done = 1'b0;
        m_if_data = 32'd0;
        m_ls_data = 32'd0;
        m_streak  = 0;
        m_wr      = 1'b0;
        m_len     = 3'd0;
        m_addr    = 32'd0;
        m_value   = 32'd0;
        m_age     = 0;
        m_lat     = 0;
    endtask

    // Controller stand-in: answers m_lat cycles into a transaction
    task automatic drive_mc();
        bus.mc_result = use_fix ? res_fix : $urandom();
        bus.mc_ready  = (m_owner != 0) && (m_age >= m_lat);
    endtask

    // Advance the model across one clock edge using the current inputs
    task automatic model_step();
        bit if_ok;
        bit ls_ok;
        bit take_if;
        if (RoB_clear) begin
            m_owner   = 0;
            m_if_done = 1'b0;
            m_ls_done = 1'b0;
            m_streak  = 0;
            return;
        end
        if (!rdy_in) return;
        if_ok = bus.if_valid && !m_if_done;
        ls_ok = bus.ls_valid && !m_ls_done;
        m_if_done = 1'b0;
        m_ls_done = 1'b0;
        if (m_owner == 0) begin
            if (if_ok || ls_ok) begin
                take_if = if_ok && (!ls_ok || m_streak == LIMIT);
                m_age = 0;
                m_lat = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
                if (take_if) begin
                    m_owner  = 1;
                    m_wr     = 1'b0;
                    m_len    = 3'b010;
                    m_addr   = bus.if_addr;
                    m_value  = 32'd0;
                    m_streak = 0;
                end else begin
                    m_owner  = 2;
                    m_wr     = bus.ls_wr;
                    m_len    = bus.ls_len;
                    m_addr   = bus.ls_addr;
                    m_value  = bus.ls_value;
                    m_streak = bus.if_valid ? ((m_streak < LIMIT) ? m_streak + 1 : LIMIT) : 0;
                end
            end
        end else if (bus.mc_ready) begin
            if (m_owner == 1) begin
                m_if_data = bus.mc_result;
                m_if_done = 1'b1;
            end else begin
                m_ls_data = bus.mc_result;
                m_ls_done = 1'b1;
            end
            m_owner = 0;
        end else begin
            m_age++;
        end
    endtask

    task automatic check_outputs();
        chk("mc_waiting", 32'(bus.mc_waiting), 32'(m_owner != 0));
        chk("if_done",    32'(bus.if_done),    32'(m_if_done));
        chk("ls_done",    32'(bus.ls_done),    32'(m_ls_done));
        chk("if_data",    bus.if_data,         m_if_data);
        chk("ls_data",    bus.ls_data,         m_ls_data);
        chk("mc_wr",      32'(bus.mc_wr),      32'(m_wr));
        chk("mc_len",     32'(bus.mc_len),     32'(m_len));
        chk("mc_addr",    bus.mc_addr,         m_addr);
        chk("mc_value",   bus.mc_value,        m_value);
    endtask

    task automatic tick();
        drive_mc();
        model_step();
        @(posedge clk_in);
        #1;
        check_outputs();
    endtask

    // Random requesters: hold valid until done, then drop or re-issue
    task automatic rand_requesters();
        if (m_if_done) begin
            if_after = 1'b1;
        end else if (if_after) begin
            if_after = 1'b0;
            if ($urandom_range(0, 1) == 0) bus.if_valid = 1'b0;
            else bus.if_addr = $urandom();
        end else if (!bus.if_valid && $urandom_range(0, 2) == 0) begin
            bus.if_valid = 1'b1;
            bus.if_addr  = $urandom();
        end else if (bus.if_valid && m_owner == 1 && $urandom_range(0, 19) == 0) begin
            bus.if_valid = 1'b0;
        end

        if (m_ls_done) begin
            ls_after = 1'b1;
        end else if (ls_after || (!bus.ls_valid && $urandom_range(0, 2) == 0)) begin
            ls_after = 1'b0;
            if (bus.ls_valid && $urandom_range(0, 1) == 0) begin
                bus.ls_valid = 1'b0;
            end else begin
                bus.ls_valid = 1'b1;
                bus.ls_wr    = 1'($urandom_range(0, 1));
                bus.ls_len   = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
                bus.ls_addr  = $urandom();
                bus.ls_value = $urandom();
            end
        end else if (m_owner == 2 && $urandom_range(0, 9) == 0) begin
            bus.ls_value = $urandom();      // must not reach the controller
        end

        rdy_in    = ($urandom_range(0, 7) != 0);
        RoB_clear = ($urandom_range(0, 29) == 0);
    endtask

    initial begin
        int ls_before [2];
        int ifs;
        int cnt;

        rst_in       = 1'b1;
        rdy_in       = 1'b1;
        RoB_clear    = 1'b0;
        bus.if_valid = 1'b0;
        bus.if_addr  = 32'd0;
        bus.ls_valid = 1'b0;
        bus.ls_wr    = 1'b0;
        bus.ls_len   = 3'd0;
        bus.ls_addr  = 32'd0;
        bus.ls_value = 32'd0;
        bus.mc_ready = 1'b0;
        bus.mc_result = 32'd0;
        lat_cfg      = -1;
        use_fix      = 1'b0;
        res_fix      = 32'd0;
        if_after     = 1'b0;
        ls_after     = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk_in);
        #3 rst_in = 1'b0;
        #1 check_outputs();

        // IF only: word fetch held stable until the controller answers
        bus.if_valid = 1'b1;
        bus.if_addr  = 32'h0000_1000;
        lat_cfg      = 4;
        use_fix      = 1'b1;
        res_fix      = 32'hDEAD_BEEF;
        for (int i = 0; i < 20 && !m_if_done; i++) begin
            tick();
            if (m_owner == 1) begin
                chk("if_mc_len",  32'(bus.mc_len), 32'h2);
                chk("if_mc_addr", bus.mc_addr,     32'h0000_1000);
            end
        end
        chk("if_only_done", 32'(bus.if_done), 32'd1);
        chk("if_only_data", bus.if_data,      32'hDEAD_BEEF);
        bus.if_valid = 1'b0;
        use_fix      = 1'b0;
        tick();
        chk("if_done_one_cycle", 32'(bus.if_done), 32'd0);

        // Contention: IF withdraws only during LSB done cycles, so each new
        // LSB grant is taken over a waiting IF and the streak builds up
        lat_cfg      = 1;
        bus.ls_valid = 1'b1;
        bus.ls_wr    = 1'b0;
        bus.ls_len   = 3'b100;
        bus.ls_addr  = 32'h0000_0020;
        bus.ls_value = 32'd0;
        bus.if_addr  = 32'h0000_2000;
        ls_before[0] = 0;
        ls_before[1] = 0;
        ifs          = 0;
        for (int i = 0; i < 200 && ifs < 2; i++) begin
            bus.if_valid = !m_ls_done;
            tick();
            if (bus.if_done) ifs++;
            else if (bus.ls_done && ifs < 2) ls_before[ifs]++;
        end
        chk("starve_if_granted",   32'(ifs),          32'd2);
        chk("starve_ls_wins",      32'(ls_before[0]), 32'd4);
        chk("starve_streak_reset", 32'(ls_before[1]), 32'd4);
        bus.if_valid = 1'b0;
        bus.ls_valid = 1'b0;
        repeat (2) tick();

        // Done-cycle masking: ls_valid stays high through its own done pulse
        lat_cfg      = 0;
        bus.ls_valid = 1'b1;
        bus.ls_wr    = 1'b1;
        bus.ls_len   = 3'b010;
        bus.ls_addr  = 32'h0000_0040;
        bus.ls_value = 32'h1234_5678;
        for (int i = 0; i < 10 && !m_ls_done; i++) tick();
        chk("mask_done_seen", 32'(bus.ls_done), 32'd1);
        tick();
        chk("mask_no_regrant", 32'(bus.mc_waiting), 32'd0);
        tick();
        chk("mask_regrant_after", 32'(bus.mc_waiting), 32'd1);
        for (int i = 0; i < 10 && !m_ls_done; i++) tick();
        bus.ls_valid = 1'b0;
        repeat (2) tick();

        // Flush in the same cycle the controller answers an IF fetch
        lat_cfg      = 2;
        bus.if_valid = 1'b1;
        bus.if_addr  = 32'h0000_3000;
        for (int i = 0; i < 10 && !(m_owner == 1 && m_age >= m_lat); i++) tick();
        RoB_clear    = 1'b1;
        bus.ls_valid = 1'b1;
        bus.ls_wr    = 1'b0;
        bus.ls_len   = 3'b001;
        bus.ls_addr  = 32'h0000_0050;
        tick();
        RoB_clear = 1'b0;
        chk("flush_no_if_done", 32'(bus.if_done),    32'd0);
        chk("flush_idle",       32'(bus.mc_waiting), 32'd0);
        tick();
        chk("flush_ls_granted", 32'(bus.mc_waiting), 32'd1);
        chk("flush_ls_addr",    bus.mc_addr,         32'h0000_0050);
        for (int i = 0; i < 30 && (bus.if_valid || bus.ls_valid || m_owner != 0); i++) begin
            if (m_ls_done) bus.ls_valid = 1'b0;
            if (m_if_done) bus.if_valid = 1'b0;
            tick();
        end
        tick();

        // Stall across an ls_done pulse
        lat_cfg      = 1;
        bus.ls_valid = 1'b1;
        bus.ls_addr  = 32'h0000_0060;
        for (int i = 0; i < 10 && !m_ls_done; i++) tick();
        rdy_in = 1'b0;
        repeat (3) begin
            tick();
            chk("stall_ls_done_hold", 32'(bus.ls_done), 32'd1);
        end
        rdy_in       = 1'b1;
        bus.ls_valid = 1'b0;
        tick();
        chk("stall_release_clear", 32'(bus.ls_done), 32'd0);

        // Asynchronous reset in the middle of a load
        lat_cfg      = 6;
        bus.ls_valid = 1'b1;
        bus.ls_addr  = 32'h0000_0070;
        for (int i = 0; i < 10 && m_owner != 2; i++) tick();
        repeat (2) tick();
        #2 rst_in = 1'b1;
        #1;
        model_reset();
        check_outputs();
        bus.ls_valid = 1'b0;
        #2 rst_in = 1'b0;
        cnt = 0;
        repeat (8) begin
            tick();
            if (bus.ls_done) cnt++;
        end
        chk("reset_no_ls_done", 32'(cnt), 32'd0);

        // Random traffic
        lat_cfg = -1;
        repeat (1500) begin
            rand_requesters();
            tick();
        end
        RoB_clear = 1'b0;
        rdy_in    = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
